// File: rtl/mem_rd_addr_gen.sv
// Read-address generator: walks a descriptor ROM and issues loop_max+1 strided reads per entry.
// Define MEM_RD_PREFETCH_EN to prefetch the next descriptor into a shadow register (no bubble).
module mem_rd_addr_gen #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned BASE_ADDR_W   = ADDR_W,
  parameter int unsigned OFFSET_ADDR_W = ADDR_W,
  parameter int unsigned TX_SIZE_WIDTH = 20,
  parameter int unsigned RD_LOOP_W     = 10,
  parameter int unsigned D_TYPE_W      = 1,
  parameter int unsigned ROM_ADDR_W    = 4,
  localparam int unsigned ROM_WIDTH    =
      D_TYPE_W + BASE_ADDR_W + OFFSET_ADDR_W + TX_SIZE_WIDTH + RD_LOOP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROM_ADDR_W-1:0]    num_cfg,
  output logic [ROM_ADDR_W-1:0]    cfg_rom_addr,
  input  logic [ROM_WIDTH-1:0]     cfg_rom_data,
  output logic                     rd_req,
  input  logic                     rd_ready,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [TX_SIZE_WIDTH-1:0] rd_req_size,
  output logic [D_TYPE_W-1:0]      rd_type,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StReq, StDone} state_e;

  // Descriptor layout, LSB first: loop_max, size, offset, base, type.
  localparam int unsigned SizeLsb = RD_LOOP_W;
  localparam int unsigned OffLsb  = SizeLsb + TX_SIZE_WIDTH;
  localparam int unsigned BaseLsb = OffLsb + OFFSET_ADDR_W;
  localparam int unsigned TypeLsb = BaseLsb + BASE_ADDR_W;

  state_e                   state_q, state_d;
  logic [ROM_ADDR_W-1:0]    idx_q, idx_d;
  logic [ROM_ADDR_W-1:0]    num_q, num_d;
  logic [RD_LOOP_W-1:0]     count_q, count_d;
  logic [ADDR_W-1:0]        acc_q, acc_d;
  logic [D_TYPE_W-1:0]      type_q, type_d;
  logic [BASE_ADDR_W-1:0]   base_q, base_d;
  logic [OFFSET_ADDR_W-1:0] offset_q, offset_d;
  logic [TX_SIZE_WIDTH-1:0] size_q, size_d;
  logic [RD_LOOP_W-1:0]     loop_q, loop_d;

  logic                     in_req;
  logic                     hs;
  logic                     last_beat;
  logic                     last_desc;
  logic                     advance;
  logic                     req_ok;
  logic                     load;
  logic [ROM_WIDTH-1:0]     desc_src;

  assign in_req    = (state_q == StReq);
  assign last_beat = (count_q == loop_q);
  assign last_desc = (idx_q == num_q);
  assign rd_req    = in_req && rd_ready && req_ok;
  assign hs        = rd_req;
  assign advance   = hs && last_beat && !last_desc;

  assign rd_addr     = ADDR_W'(base_q) + acc_q;
  assign rd_req_size = size_q;
  assign rd_type     = type_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

`ifdef MEM_RD_PREFETCH_EN
  logic [ROM_WIDTH-1:0] shadow_q;
  logic                 shadow_vld_q;
  // High when cfg_rom_data currently holds descriptor idx_q+1.
  logic                 rom_nxt_q;

  assign cfg_rom_addr = in_req ? idx_q + 1'b1 : idx_q;
  assign desc_src     = in_req ? shadow_q : cfg_rom_data;
  // Only the hand-off beat of a non-final descriptor has to wait for the shadow.
  assign req_ok       = !last_beat || last_desc || shadow_vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      rom_nxt_q    <= 1'b0;
    end else begin
      rom_nxt_q <= in_req && !advance;
      if (!in_req || advance) begin
        shadow_vld_q <= 1'b0;
      end else if (rom_nxt_q && !shadow_vld_q) begin
        shadow_q     <= cfg_rom_data;
        shadow_vld_q <= 1'b1;
      end
    end
  end
`else
  assign cfg_rom_addr = idx_q;
  assign desc_src     = cfg_rom_data;
  assign req_ok       = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    count_d  = count_q;
    acc_d    = acc_q;
    type_d   = type_q;
    base_d   = base_q;
    offset_d = offset_q;
    size_d   = size_q;
    loop_d   = loop_q;
    load     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d   = num_cfg;
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        load    = 1'b1;
        state_d = StReq;
      end
      StReq: begin
        if (hs) begin
          if (!last_beat) begin
            acc_d   = acc_q + ADDR_W'(offset_q);
            count_d = count_q + 1'b1;
          end else if (!last_desc) begin
            idx_d = idx_q + 1'b1;
`ifdef MEM_RD_PREFETCH_EN
            load  = 1'b1;
`else
            state_d = StFetch;
`endif
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (load) begin
      type_d   = desc_src[TypeLsb +: D_TYPE_W];
      base_d   = desc_src[BaseLsb +: BASE_ADDR_W];
      offset_d = desc_src[OffLsb +: OFFSET_ADDR_W];
      size_d   = desc_src[SizeLsb +: TX_SIZE_WIDTH];
      loop_d   = desc_src[0 +: RD_LOOP_W];
      count_d  = '0;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      num_q    <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      type_q   <= '0;
      base_q   <= '0;
      offset_q <= '0;
      size_q   <= '0;
      loop_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      type_q   <= type_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      size_q   <= size_d;
      loop_q   <= loop_d;
    end
  end

endmodule

// File: tb/tb_mem_rd_addr_gen.sv
// Directed bench for mem_rd_addr_gen: per-cycle vector tables plus hand-written corner sequences.
module tb_mem_rd_addr_gen;

  localparam int RW   = 1 + 32 + 32 + 20 + 10;
  localparam int RW16 = 1 + 16 + 16 + 20 + 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, rd_ready;
  logic [3:0]    num_cfg, cfg_rom_addr;
  logic [RW-1:0] cfg_rom_data;
  logic          rd_req, busy, done;
  logic [31:0]   rd_addr;
  logic [19:0]   rd_req_size;
  logic [0:0]    rd_type;
  logic [RW-1:0] rom [16];

  logic            start16, rd_ready16;
  logic [3:0]      num16, cfg_rom_addr16;
  logic [RW16-1:0] cfg_rom_data16;
  logic            rd_req16, busy16, done16;
  logic [15:0]     rd_addr16;
  logic [19:0]     rd_req_size16;
  logic [0:0]      rd_type16;

  always @(posedge clk) cfg_rom_data <= rom[cfg_rom_addr];
  always @(posedge clk) cfg_rom_data16 <= {1'b0, 16'hFFF0, 16'h0010, 20'd16, 10'd1};

  mem_rd_addr_gen dut (
    .clk(clk), .reset(reset), .start(start), .num_cfg(num_cfg),
    .cfg_rom_addr(cfg_rom_addr), .cfg_rom_data(cfg_rom_data),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_req_size(rd_req_size),
    .rd_type(rd_type), .busy(busy), .done(done)
  );

  mem_rd_addr_gen #(.ADDR_W(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .num_cfg(num16),
    .cfg_rom_addr(cfg_rom_addr16), .cfg_rom_data(cfg_rom_data16),
    .rd_req(rd_req16), .rd_ready(rd_ready16), .rd_addr(rd_addr16),
    .rd_req_size(rd_req_size16), .rd_type(rd_type16), .busy(busy16), .done(done16)
  );

  typedef struct {
    logic        rdy;
    logic        req;
    logic        chk;
    logic [31:0] addr;
    logic [19:0] size;
    logic        typ;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vt [30];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(input logic rdy, input logic req, input logic chk,
                              input logic [31:0] addr, input logic [19:0] size,
                              input logic typ, input logic bsy, input logic dn);
    vec_t v;
    v.rdy = rdy; v.req = req; v.chk = chk; v.addr = addr; v.size = size;
    v.typ = typ; v.busy = bsy; v.done = dn;
    return v;
  endfunction

  function automatic logic [RW-1:0] desc(input logic t, input logic [31:0] b,
                                         input logic [31:0] o, input logic [19:0] s,
                                         input logic [9:0] l);
    return {t, b, o, s, l};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_seg(input int first, input int n, input logic [3:0] num);
    @(negedge clk);
    start   = 1'b1;
    num_cfg = num;
    for (int i = first; i < first + n; i++) begin
      @(negedge clk);
      start    = 1'b0;
      num_cfg  = 4'd0;
      rd_ready = vt[i].rdy;
      #1;
      check($sformatf("v%0d_req", i), 64'(rd_req), 64'(vt[i].req));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'(vt[i].busy));
      check($sformatf("v%0d_done", i), 64'(done), 64'(vt[i].done));
      if (vt[i].req || vt[i].chk)
        check($sformatf("v%0d_addr", i), 64'(rd_addr), 64'(vt[i].addr));
      if (vt[i].req) begin
        check($sformatf("v%0d_size", i), 64'(rd_req_size), 64'(vt[i].size));
        check($sformatf("v%0d_type", i), 64'(rd_type), 64'(vt[i].typ));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, 64'(rd_req), 64'd0);
    check({tag, "_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_size"}, 64'(rd_req_size), 64'd0);
    check({tag, "_type"}, 64'(rd_type), 64'd0);
    check({tag, "_romaddr"}, 64'(cfg_rom_addr), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int reqs, dones, n16, d16;
    logic [15:0] a16 [4];

    // Single descriptor, rd_ready held high.
    vt[0]  = mk(1, 0, 0, 32'h0,    0,   0, 1, 0);
    vt[1]  = mk(1, 0, 0, 32'h0,    0,   0, 1, 0);
    vt[2]  = mk(1, 1, 1, 32'h100,  64,  0, 1, 0);
    vt[3]  = mk(1, 1, 1, 32'h110,  64,  0, 1, 0);
    vt[4]  = mk(1, 1, 1, 32'h120,  64,  0, 1, 0);
    vt[5]  = mk(1, 1, 1, 32'h130,  64,  0, 1, 0);
    vt[6]  = mk(1, 0, 0, 32'h0,    0,   0, 1, 1);
    vt[7]  = mk(1, 0, 0, 32'h0,    0,   0, 0, 0);
    // Two single-request descriptors, FETCH/LOAD bubble between them.
    vt[8]  = mk(1, 0, 0, 32'h0,    0,   0, 1, 0);
    vt[9]  = mk(1, 0, 0, 32'h0,    0,   0, 1, 0);
    vt[10] = mk(1, 1, 1, 32'h0,    32,  0, 1, 0);
    vt[11] = mk(1, 0, 0, 32'h0,    0,   0, 1, 0);
    vt[12] = mk(1, 0, 0, 32'h0,    0,   0, 1, 0);
    vt[13] = mk(1, 1, 1, 32'h1000, 128, 1, 1, 0);
    vt[14] = mk(1, 0, 0, 32'h0,    0,   0, 1, 1);
    vt[15] = mk(1, 0, 0, 32'h0,    0,   0, 0, 0);
    // Single descriptor, rd_ready pattern 1,0,0 repeating; address holds while stalled.
    vt[16] = mk(0, 0, 0, 32'h0,    0,   0, 1, 0);
    vt[17] = mk(0, 0, 0, 32'h0,    0,   0, 1, 0);
    vt[18] = mk(1, 1, 1, 32'h100,  64,  0, 1, 0);
    vt[19] = mk(0, 0, 1, 32'h110,  0,   0, 1, 0);
    vt[20] = mk(0, 0, 1, 32'h110,  0,   0, 1, 0);
    vt[21] = mk(1, 1, 1, 32'h110,  64,  0, 1, 0);
    vt[22] = mk(0, 0, 1, 32'h120,  0,   0, 1, 0);
    vt[23] = mk(0, 0, 1, 32'h120,  0,   0, 1, 0);
    vt[24] = mk(1, 1, 1, 32'h120,  64,  0, 1, 0);
    vt[25] = mk(0, 0, 1, 32'h130,  0,   0, 1, 0);
    vt[26] = mk(0, 0, 1, 32'h130,  0,   0, 1, 0);
    vt[27] = mk(1, 1, 1, 32'h130,  64,  0, 1, 0);
    vt[28] = mk(0, 0, 0, 32'h0,    0,   0, 1, 1);
    vt[29] = mk(0, 0, 0, 32'h0,    0,   0, 0, 0);

    for (int i = 0; i < 16; i++) rom[i] = '0;
    reset = 1'b1; start = 1'b0; rd_ready = 1'b0; num_cfg = 4'd0;
    start16 = 1'b0; rd_ready16 = 1'b1; num16 = 4'd0;
    repeat (2) @(negedge clk);
    rd_ready = 1'b1;
    #1;
    check_zero("rst");
    check("rst_addr16", 64'(rd_addr16), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    rom[0] = desc(1'b0, 32'h100, 32'h10, 20'd64, 10'd3);
    run_seg(0, 8, 4'd0);

    rom[0] = desc(1'b0, 32'h0, 32'h40, 20'd32, 10'd0);
    rom[1] = desc(1'b1, 32'h1000, 32'h40, 20'd128, 10'd0);
    run_seg(8, 8, 4'd1);

    rom[0] = desc(1'b0, 32'h100, 32'h10, 20'd64, 10'd3);
    run_seg(16, 14, 4'd0);

    // Reset after the second request aborts the pass with no done.
    reqs = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start    = 1'b0;
      rd_ready = 1'b1;
      #1;
      if (rd_req) reqs++;
    end
    check("abort_pre_reqs", 64'(reqs), 64'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_zero("abort");
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("abort_idle%0d", c), 64'({busy, done}), 64'd0);
    end
    run_seg(0, 8, 4'd0);

    // start pulses while busy are ignored.
    reqs = 0;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start    = (c == 1 || c == 3 || c == 5);
      rd_ready = 1'b1;
      #1;
      if (rd_req) reqs++;
      if (done) dones++;
    end
    check("rebusy_reqs", 64'(reqs), 64'd4);
    check("rebusy_dones", 64'(dones), 64'd1);
    check("rebusy_idle", 64'(busy), 64'd0);

    // 16-bit address wrap.
    n16 = 0;
    d16 = 0;
    @(negedge clk);
    start16 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start16 = 1'b0;
      #1;
      if (rd_req16) begin
        if (n16 < 4) a16[n16] = rd_addr16;
        n16++;
      end
      if (done16) d16++;
    end
    check("wrap_reqs", 64'(n16), 64'd2);
    if (n16 >= 2) begin
      check("wrap_addr0", 64'(a16[0]), 64'hFFF0);
      check("wrap_addr1", 64'(a16[1]), 64'h0000);
    end
    check("wrap_dones", 64'(d16), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
